// File: rtl/apb_reg_native_pkg.sv
// Shared types and constants for the APB3 to reg_native bridge.
// Holds the FSM state encoding and the debug error-cause codes.
package apb_reg_native_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    RESP
  } state_t;

  localparam int BYTE_OFFSET_W = 2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/apb_reg_native_bridge_timeout_cnt.sv
// Ack timeout counter for the bridge WAIT_ACK state; only instantiated when
// APB_REG_NATIVE_TIMEOUT_EN is defined.
module reg_native_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the last ack-less WAIT_ACK cycle the bridge will tolerate.
  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_reg_native_bridge.sv
// APB3 slave to reg_native master bridge: one single-cycle request per transfer.
// Define APB_REG_NATIVE_TIMEOUT_EN to enable the ack timeout error path.
module apb_reg_native_bridge
  import apb_reg_native_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int PADDR_WIDTH = 16,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   req_vld,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   ack_vld,
  input  logic [DATA_WIDTH-1:0]  rd_data
);

  if (PADDR_WIDTH < ADDR_WIDTH + BYTE_OFFSET_W || TIMEOUT < 2) begin : g_param_check
    $error("apb_reg_native_bridge: illegal PADDR_WIDTH or TIMEOUT");
  end

  state_t          state, state_nxt;
  logic [1:0]      err_cause, err_nxt;
  logic            wr_q;
  logic            setup, addr_bad, start, issue, respond, ack_take, expired;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign setup     = psel & ~penable;
  assign word_addr = paddr[BYTE_OFFSET_W +: ADDR_WIDTH];
  // Shift rather than slice so PADDR_WIDTH == ADDR_WIDTH+2 stays legal.
  assign addr_bad  = (paddr[BYTE_OFFSET_W-1:0] != '0) ||
                     ((paddr >> (ADDR_WIDTH + BYTE_OFFSET_W)) != '0);
  assign start     = (state == IDLE) & setup;
  assign ack_take  = (state == WAIT_ACK) & ack_vld;
  assign issue     = (state_nxt == REQ);
  assign respond   = (state_nxt == RESP);

`ifdef APB_REG_NATIVE_TIMEOUT_EN
  reg_native_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT_ACK),
    .en      ((state == WAIT_ACK) & ~ack_vld),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = err_cause;
    case (state)
      IDLE: begin
        if (setup) begin
          err_nxt   = addr_bad ? ERR_ADDR : ERR_NONE;
          state_nxt = addr_bad ? RESP : REQ;
        end
      end
      REQ:      state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        // An ack in the final counted cycle takes priority over the timeout.
        if (ack_vld) begin
          err_nxt   = ERR_NONE;
          state_nxt = RESP;
        end else if (expired) begin
          err_nxt   = ERR_TIMEOUT;
          state_nxt = RESP;
        end
      end
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      err_cause <= ERR_NONE;
      wr_q      <= 1'b0;
      req_vld   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      state     <= state_nxt;
      err_cause <= err_nxt;
      if (start) begin
        wr_q <= pwrite;
      end
      req_vld <= issue;
      wr_en   <= issue & pwrite;
      rd_en   <= issue & ~pwrite;
      if (issue) begin
        addr    <= word_addr;
        wr_data <= pwdata;
      end
      pready  <= respond;
      pslverr <= respond & (err_nxt != ERR_NONE);
      prdata  <= (respond & ack_take & ~wr_q) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_apb_reg_native_bridge.sv
// Directed bench for apb_reg_native_bridge: vector table plus reset, psel-drop
// and no-ack sequences against a small reg_native memory target.
module tb_apb_reg_native_bridge;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int PW = 16;
  localparam int TO = 16;
  localparam int BUDGET = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [PW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata, wr_data, rd_data;
  logic          pready, pslverr, req_vld, wr_en, rd_en, ack_vld;
  logic [AW-1:0] addr;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  apb_reg_native_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PADDR_WIDTH(PW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .ack_vld(ack_vld), .rd_data(rd_data)
  );

  // ---------------- reg_native target model ----------------
  logic          tgt_ack = 1'b0;
  logic [DW-1:0] tgt_rd  = '0;
  logic          man_ack = 1'b0;
  logic [DW-1:0] man_rd  = '0;
  int            tgt_delay = 2;
  int            tgt_cnt   = 0;
  logic [DW-1:0] mem [64];

  assign ack_vld = tgt_ack | man_ack;
  assign rd_data = man_ack ? man_rd : tgt_rd;

  always @(posedge clk) begin
    tgt_ack <= 1'b0;
    if (rst) begin
      tgt_cnt <= 0;
    end else begin
      if (tgt_cnt == 1) tgt_ack <= 1'b1;
      if (tgt_cnt > 0) tgt_cnt <= tgt_cnt - 1;
      if (req_vld) begin
        if (wr_en) mem[addr] <= wr_data;
        tgt_rd <= wr_en ? wr_data : mem[addr];
        if (tgt_delay == 1) tgt_ack <= 1'b1;
        else if (tgt_delay > 1) tgt_cnt <= tgt_delay - 1;
      end
    end
  end

  // Request monitor
  int            req_cnt = 0;
  logic [AW-1:0] mon_addr;
  logic          mon_wr, mon_rd;
  logic [DW-1:0] mon_wdata;

  always @(posedge clk) begin
    if (!rst && req_vld === 1'b1) begin
      req_cnt   <= req_cnt + 1;
      mon_addr  <= addr;
      mon_wr    <= wr_en;
      mon_rd    <= rd_en;
      mon_wdata <= wr_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pslverr/prdata must stay low outside the pready pulse.
  always @(negedge clk) begin
    if (!rst && pready === 1'b0) begin
      chk("idle_pslverr", {31'b0, pslverr}, 32'h0);
      chk("idle_prdata", prdata, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at the negedge just after the setup edge; lat counts from the start
  // of the setup phase to the edge where pready is sampled.
  task automatic wait_pready(output int lat);
    lat = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (pready === 1'b1) begin
        lat = k + 1;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) chk("pready_wait_expired", 32'h0, 32'h1);
  endtask

  task automatic apb_xfer(input logic w, input logic [PW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] rdat, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    wait_pready(lat);
    rdat = prdata;
    err  = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          w;
    logic [PW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
    int            exp_req;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_prdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [PW-1:0] a, logic [DW-1:0] d, int dly,
                              int req, logic [AW-1:0] ea, logic [DW-1:0] ep, logic ee, int el);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.dly = dly; v.exp_req = req; v.exp_addr = ea;
    v.exp_prdata = ep; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  int            lat, rc0;
  logic [DW-1:0] rdat;
  logic          err;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    vecs.push_back(mk(1, 16'h0010, 32'hDEADBEEF, 2, 1, 6'd4,  32'h0,        0, 5));
    vecs.push_back(mk(0, 16'h0010, 32'h0,        2, 1, 6'd4,  32'hDEADBEEF, 0, 5));
    vecs.push_back(mk(1, 16'h0012, 32'h11111111, 2, 0, 6'd0,  32'h0,        1, 2));
    vecs.push_back(mk(0, 16'h0100, 32'h0,        2, 0, 6'd0,  32'h0,        1, 2));
    vecs.push_back(mk(1, 16'h0000, 32'h00000001, 2, 1, 6'd0,  32'h0,        0, 5));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        2, 1, 6'd0,  32'h00000001, 0, 5));
    vecs.push_back(mk(1, 16'h00FC, 32'hA5A50F0F, 1, 1, 6'd63, 32'h0,        0, 4));
    vecs.push_back(mk(0, 16'h00FC, 32'h0,        1, 1, 6'd63, 32'hA5A50F0F, 0, 4));
    vecs.push_back(mk(0, 16'h8000, 32'h0,        2, 0, 6'd0,  32'h0,        1, 2));
    vecs.push_back(mk(1, 16'h0003, 32'h22222222, 2, 0, 6'd0,  32'h0,        1, 2));
    vecs.push_back(mk(1, 16'h0004, 32'h12345678, 3, 1, 6'd1,  32'h0,        0, 6));
    vecs.push_back(mk(0, 16'h0004, 32'h0,        5, 1, 6'd1,  32'h12345678, 0, 8));
    // Ack in the 16th WAIT_ACK cycle still completes cleanly.
    vecs.push_back(mk(0, 16'h0010, 32'h0,       16, 1, 6'd4,  32'hDEADBEEF, 0, 19));
`ifdef APB_REG_NATIVE_TIMEOUT_EN
    vecs.push_back(mk(0, 16'h0010, 32'h0,       17, 1, 6'd4,  32'h0,        1, 19));
`else
    vecs.push_back(mk(0, 16'h0010, 32'h0,       17, 1, 6'd4,  32'hDEADBEEF, 0, 20));
    vecs.push_back(mk(0, 16'h0004, 32'h0,       40, 1, 6'd1,  32'h12345678, 0, 43));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pready",  {31'b0, pready},  32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata",  prdata,           32'h0);
    chk("rst_req_vld", {31'b0, req_vld}, 32'h0);
    chk("rst_wr_en",   {31'b0, wr_en},   32'h0);
    chk("rst_rd_en",   {31'b0, rd_en},   32'h0);
    chk("rst_addr",    {26'b0, addr},    32'h0);
    chk("rst_wr_data", wr_data,          32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven transfers
    foreach (vecs[i]) begin
      tgt_delay = vecs[i].dly;
      rc0 = req_cnt;
      exp_q.push_back(vecs[i].exp_prdata);
      apb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, lat, rdat, err);
      chk($sformatf("v%0d_req_cnt", i), 32'(req_cnt - rc0), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req == 1) begin
        chk($sformatf("v%0d_addr", i),  {26'b0, mon_addr}, {26'b0, vecs[i].exp_addr});
        chk($sformatf("v%0d_wr_en", i), {31'b0, mon_wr},   {31'b0, vecs[i].w});
        chk($sformatf("v%0d_rd_en", i), {31'b0, mon_rd},   {31'b0, ~vecs[i].w});
        if (vecs[i].w) chk($sformatf("v%0d_wr_data", i), mon_wdata, vecs[i].d);
      end
      chk($sformatf("v%0d_prdata", i),  rdat, exp_q.pop_front());
      chk($sformatf("v%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

`ifdef APB_REG_NATIVE_TIMEOUT_EN
    // Target never acks: timeout error 16 cycles after entering WAIT_ACK.
    tgt_delay = 0;
    apb_xfer(1'b0, 16'h0000, 32'h0, lat, rdat, err);
    chk("noack_pslverr", {31'b0, err}, 32'h1);
    chk("noack_prdata",  rdat,         32'h0);
    chk("noack_latency", 32'(lat),     32'd19);
`endif

    // Stray/late ack while idle must not produce a response.
    tgt_delay = 2;
    rc0 = req_cnt;
    man_rd = 32'h0BAD0BAD; man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("late_ack_pready", {31'b0, pready}, 32'h0);
      @(negedge clk);
    end
    chk("late_ack_req_cnt", 32'(req_cnt - rc0), 32'h0);

    // psel dropped before pready: access still completes.
    tgt_delay = 3;
    rc0 = req_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h00000077;
    @(negedge clk);
    psel = 1'b0;
    wait_pready(lat);
    chk("drop_pslverr", {31'b0, pslverr}, 32'h0);
    chk("drop_latency", 32'(lat), 32'd6);
    @(negedge clk);
    chk("drop_req_cnt", 32'(req_cnt - rc0), 32'h1);
    tgt_delay = 2;
    apb_xfer(1'b0, 16'h0008, 32'h0, lat, rdat, err);
    chk("drop_readback", rdat, 32'h00000077);

    // Reset during WAIT_ACK of a read, ack arrives two cycles after reset.
    tgt_delay = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
    @(negedge clk);
    penable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pready",  {31'b0, pready},  32'h0);
    chk("midrst_req_vld", {31'b0, req_vld}, 32'h0);
    chk("midrst_rd_en",   {31'b0, rd_en},   32'h0);
    chk("midrst_addr",    {26'b0, addr},    32'h0);
    chk("midrst_prdata",  prdata,           32'h0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    man_rd = 32'hCAFE0001; man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_ack_pready", {31'b0, pready}, 32'h0);
      @(negedge clk);
    end
    tgt_delay = 2;
    apb_xfer(1'b1, 16'h0020, 32'h00000055, lat, rdat, err);
    chk("postrst_wr_latency", 32'(lat), 32'd5);
    chk("postrst_wr_pslverr", {31'b0, err}, 32'h0);
    chk("postrst_wr_addr", {26'b0, mon_addr}, 32'd8);
    apb_xfer(1'b0, 16'h0020, 32'h0, lat, rdat, err);
    chk("postrst_readback", rdat, 32'h00000055);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- final report guard ----------------
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
